bram_stream_reader: RTL

- Read-side client for the single-port synchronous BRAM (1-cycle registered read, write-first port shared with writes).
- Accepts a (start address, length) command, issues sequential reads, and emits the words as a valid/ready stream with a last flag.
- Absorbs the BRAM's fixed 1-cycle read latency under downstream backpressure with a 2-entry output buffer, so no word is dropped or duplicated.
- Sits between a BRAM instance and any streaming consumer (traceback/output packers).

---
 rtl/bram_stream_pkg.sv | 22 ++
 rtl/bram_stream_reader_skid_fifo2.sv | 76 +++++++
 rtl/bram_stream_reader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bram_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_pkg
// Description : Shared types and constants for the BRAM stream reader.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_stream_pkg;

    // Control states of the reader
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Output buffer depth: one slot for the word being presented plus one
    // slot to absorb the word already in flight from the BRAM.
    localparam int c_fifo_depth = 2;

endpackage : bram_stream_pkg
`default_nettype wire

// File: rtl/bram_stream_reader_skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : skid_fifo2
// Description : 2-entry synchronous FIFO with push/pop/full/empty. A push
//               into a full FIFO is accepted only when a pop happens in the
//               same cycle, so the entry count stays unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_fifo2
    import bram_stream_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] mem_q [c_fifo_depth];
    logic [WIDTH-1:0] mem_d [c_fifo_depth];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q,  count_d;
    logic             w_do_push;
    logic             w_do_pop;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        w_do_pop  = i_pop && (count_q != 2'd0);
        w_do_push = i_push && ((count_q != 2'd2) || w_do_pop);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = i_push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (w_do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset clears data so the head reads 0
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_pop_data = mem_q[rd_ptr_q];
    assign o_full     = (count_q == 2'd2);
    assign o_empty    = (count_q == 2'd0);
    assign o_count    = count_q;

endmodule : skid_fifo2
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader
// Description : Reads a (start, length) run of words from a single-port
//               synchronous BRAM and emits them as a valid/ready stream with
//               a last flag. A 2-entry buffer plus a credit check absorbs the
//               BRAM's 1-cycle read latency under backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_start_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } entry_t;

    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   c_rem_one  = (ADDR_WIDTH + 1)'(1);

    state_e                state_q,         state_d;
    logic [ADDR_WIDTH-1:0] addr_q,          addr_d;
    logic [ADDR_WIDTH:0]   remaining_q,     remaining_d;
    logic                  inflight_q,      inflight_d;
    logic                  inflight_last_q, inflight_last_d;

    logic                  w_issue;
    logic                  w_pop;
    logic                  w_credit_ok;
    logic [2:0]            w_occupied;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [1:0]            w_fifo_count;
    entry_t                w_push_entry;
    entry_t                w_head_entry;

    // The word returning from the BRAM this cycle carries the last flag
    // captured when its read was issued.
    assign w_push_entry = {mem_data_out, inflight_last_q};

    skid_fifo2 #(
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (inflight_q),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_pop_data  (w_head_entry),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // Issue decision and FSM next-state. The credit check counts buffered
    // words plus the read in flight, less the word leaving this cycle, so a
    // steady consumer sees one word per cycle with no bubbles while the
    // buffer can never be pushed past two entries.
    always_comb begin
        w_pop           = !w_fifo_empty && out_ready;
        w_occupied      = {1'b0, w_fifo_count} + {2'b00, inflight_q} - {2'b00, w_pop};
        w_credit_ok     = (w_occupied < 3'd2);
        w_issue         = (state_q == READ) && (remaining_q != '0) && w_credit_ok;

        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        inflight_d      = w_issue;
        inflight_last_d = w_issue && (remaining_q == c_rem_one);

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_d      = cmd_start_addr;
                        remaining_d = cmd_len;
                        state_d     = READ;
                    end
                end
            end
            READ: begin
                if (w_issue) begin
                    remaining_d = remaining_q - c_rem_one;
                    if (remaining_q == c_rem_one) begin
                        // Final read: hold the address, nothing more to fetch
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + c_addr_one;
                    end
                end
            end
            DRAIN: begin
                // Finish at the edge where the last buffered word leaves
                if (!inflight_q &&
                    (w_fifo_empty || ((w_fifo_count == 2'd1) && w_pop))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; reset aborts any command and drops the read in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_write_en = 1'b0;
    assign mem_data_in  = '0;
    assign out_valid    = !w_fifo_empty;
    assign out_data     = w_head_entry.data;
    assign out_last     = w_head_entry.last;
    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(inflight_q && w_fifo_full && !w_pop));

endmodule : bram_stream_reader
`default_nettype wire
